// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_BYTE_W  = 8;
    localparam int unsigned DEF_PRESCALE = 868;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping to 0.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr, 32'(k));
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional watchdog on the busy handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned PRESC_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [PRESC_W*NUM_REQ-1:0]     req_prescale,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           uart_tx_start,
    output logic [UART_BYTE_W-1:0]         uart_tx_data,
    output logic [PRESC_W-1:0]             uart_prescale,
    input  logic                           uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           arb_busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [UART_BYTE_W-1:0]   data_q, data_d;
    logic [PRESC_W-1:0]       presc_q, presc_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;

    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             tmo_hit_c;

    // Fires on the last of TIMEOUT_CYC cycles spent waiting in one state.
    assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_c;
    assign unused_tmo_c = ^32'(TIMEOUT_CYC);
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        presc_d  = presc_q;
        ack_d    = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SETUP;
                    grant_d = pick_idx;
                    data_d  = req_data[32'(pick_idx)*UART_BYTE_W +: UART_BYTE_W];
                    presc_d = req_prescale[32'(pick_idx)*PRESC_W +: PRESC_W];
                end
            end
            ST_SETUP: state_d = ST_START;
            ST_START: begin
                state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (tmo_hit_c) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = ST_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (tmo_hit_c) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the state being entered.
        if (state_d == ST_DONE) ack_d[grant_d] = 1'b1;
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            presc_q  <= PRESC_W'(DEF_PRESCALE);
            ack_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            presc_q  <= presc_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign ack           = ack_q;
    assign uart_tx_start = start_q;
    assign uart_tx_data  = data_q;
    assign uart_prescale = presc_q;
    assign grant_id      = grant_q;
    assign arb_busy      = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err   = tmo_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin queue model predicts grants,
// a monitor with a simple UART model checks them. Timeout cases need UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 4096;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_data;
    logic [PW*N-1:0] req_prescale;
    logic [N-1:0]    ack;
    logic            uart_tx_start;
    logic [7:0]      uart_tx_data;
    logic [PW-1:0]   uart_prescale;
    logic            uart_tx_busy;
    logic [1:0]      grant_id;
    logic            arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .PRESC_W(PW), .TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_prescale  (req_prescale),
        .ack           (ack),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_prescale (uart_prescale),
        .uart_tx_busy  (uart_tx_busy),
        .grant_id      (grant_id),
        .arb_busy      (arb_busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [7:0]    data;
        logic [PW-1:0] presc;
    } exp_t;

    exp_t exp_q[$];
    int   drv_order[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    int            rem   [N];
    bit            early [N];
    logic [7:0]    dat   [N];
    logic [PW-1:0] prs   [N];
    int            rr_model  = 0;
    bit            long_busy = 1'b0;
    bit            tie0      = 1'b0;
    bit            expect_tmo = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    endtask

    // Monitor plus UART model: owns uart_tx_busy and pops the scoreboard.
    initial begin : monitor
        exp_t          cur;
        bit            in_flight;
        logic [7:0]    rx_byte, last_data;
        logic [PW-1:0] last_presc;
        int            phase, dly, blen;
        in_flight = 1'b0; rx_byte = '0; last_data = '0; last_presc = PW'(868);
        phase = 0; dly = 0; blen = 0;
        cur = '{idx: 0, data: 8'h00, presc: '0};
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight = 1'b0; phase = 0; uart_tx_busy = 1'b0;
                last_data = '0; last_presc = PW'(868);
                continue;
            end
            if (ack != '0) begin
                check(in_flight && (ack == (N'(1) << cur.idx)), "ack_onehot",
                      longint'(ack), in_flight ? (longint'(1) << cur.idx) : 0);
                check(rx_byte == cur.data, "rx_byte", rx_byte, cur.data);
                in_flight = 1'b0;
            end
            if (uart_tx_start) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_start", uart_tx_data, 0);
                end else begin
                    cur = exp_q.pop_front();
                    in_flight = 1'b1;
                    check(32'(grant_id) == cur.idx, "grant_id", grant_id, cur.idx);
                    check(uart_tx_data == cur.data, "tx_data", uart_tx_data, cur.data);
                    check(uart_prescale == cur.presc, "prescale", uart_prescale, cur.presc);
                    last_data = cur.data; last_presc = cur.presc;
                    rx_byte = uart_tx_data;
                    phase = 1;
                    dly  = $urandom_range(0, 2);
                    blen = long_busy ? 10 : $urandom_range(1, 5);
                end
            end else if (in_flight) begin
                check(uart_tx_data == cur.data && uart_prescale == cur.presc, "hold_xfer",
                      {uart_tx_data, uart_prescale}, {cur.data, cur.presc});
            end else if (!arb_busy) begin
                check(uart_tx_data == last_data && uart_prescale == last_presc, "hold_idle",
                      {uart_tx_data, uart_prescale}, {last_data, last_presc});
            end
            case (phase)
                1: if (dly == 0) begin uart_tx_busy = !tie0; phase = 2; end else dly--;
                2: if (blen == 0) begin uart_tx_busy = 1'b0; phase = 0; end else blen--;
                default: ;
            endcase
        end
    end

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; early[i] = 1'b0; dat[i] = 8'($urandom); prs[i] = PW'($urandom);
        end
    endtask

    // Reference: each pending requester is served in cyclic order from the pointer.
    task automatic model_push();
        int r [N];
        int left;
        left = 0;
        for (int i = 0; i < N; i++) begin r[i] = rem[i]; left += rem[i]; end
        while (left > 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr_model + k) % N;
                if (r[j] > 0) begin
                    exp_q.push_back('{idx: j, data: dat[j], presc: prs[j]});
                    drv_order.push_back(j);
                    r[j]--; left--;
                    rr_model = (j + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic load_and_raise();
        for (int i = 0; i < N; i++) begin
            req_data[8*i +: 8]     = dat[i];
            req_prescale[PW*i +: PW] = prs[i];
        end
        model_push();
        for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
    endtask

    task automatic run_batch(input string tag);
        int n, first_start, to_at, f;
        load_and_raise();
        n = 0; first_start = -1; to_at = -1;
        while (drv_order.size() > 0) begin
            @(negedge clk); n++;
            if (n > 3000) begin
                $display("FAIL %s: batch did not complete, %0d transfers outstanding", tag, drv_order.size());
                $fatal(1);
            end
            if (uart_tx_start && first_start < 0) first_start = n;
`ifdef UART_ARB_TIMEOUT_EN
            if (timeout_err) begin
                to_at = n;
                check(ack != '0, "ack_with_timeout", ack, 1);
            end
`endif
            if (ack != '0) begin
                f = drv_order.pop_front();
                rem[f]--;
                if (rem[f] == 0) req[f] = 1'b0;
            end else if (uart_tx_busy && early[drv_order[0]] && rem[drv_order[0]] == 1) begin
                req[drv_order[0]] = 1'b0;
            end
        end
        check(first_start == 2, "start_latency", first_start, 2);
        if (expect_tmo) check(to_at - first_start == 17, "timeout_delay", to_at - first_start, 17);
        else            check(to_at < 0, "no_timeout", to_at, -1);
        repeat (2) @(negedge clk);
        check(arb_busy == 1'b0, "idle_after_batch", arb_busy, 0);
    endtask

    initial begin : driver
        rst = 1'b1; req = '0; req_data = '0; req_prescale = '0;
        repeat (3) @(negedge clk);
        check(arb_busy == 0 && uart_tx_start == 0 && ack == '0, "reset_ctrl",
              {arb_busy, uart_tx_start, ack}, 0);
        check(grant_id == 0 && uart_tx_data == 8'h00, "reset_grant_data", {grant_id, uart_tx_data}, 0);
        check(uart_prescale == PW'(868), "reset_prescale", uart_prescale, 868);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two simultaneous requesters with very different dividers.
        clr(); rem[0] = 1; rem[2] = 1; prs[0] = PW'(10416); prs[2] = PW'(100);
        run_batch("presc_pair");

        // Single requester 0, byte 0xA5 at the default divider.
        clr(); rem[0] = 1; dat[0] = 8'hA5; prs[0] = PW'(868);
        run_batch("single_a5");

        // Requester 1 lets go while the byte is still on the wire.
        clr(); rem[1] = 1; early[1] = 1'b1; long_busy = 1'b1;
        run_batch("early_drop");
        long_busy = 1'b0;

        // Reset in the middle of a transfer.
        begin : rst_mid
            int n;
            clr(); rem[2] = 1; long_busy = 1'b1;
            load_and_raise();
            n = 0;
            while (!uart_tx_busy) begin
                @(negedge clk); n++;
                if (n > 50) begin
                    $display("FAIL rst_mid_wait: busy never seen");
                    $fatal(1);
                end
            end
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            check(uart_tx_start == 0 && arb_busy == 0 && ack == '0, "rst_mid_ctrl",
                  {uart_tx_start, arb_busy, ack}, 0);
            check(uart_prescale == PW'(868) && uart_tx_data == 8'h00, "rst_mid_data",
                  {uart_tx_data, uart_prescale}, 868);
            req = '0; exp_q.delete(); drv_order.delete();
            for (int i = 0; i < N; i++) rem[i] = 0;
            rr_model = 0; long_busy = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (12) @(negedge clk);
            check(arb_busy == 0, "rst_mid_idle", arb_busy, 0);
        end

        // All four held, requester 0 twice: order 0,1,2,3,0.
        clr(); rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        run_batch("all_held");

        for (int b = 0; b < 25; b++) begin
            int any;
            clr(); any = 0;
            for (int i = 0; i < N; i++) begin
                rem[i] = $urandom_range(0, 2);
                early[i] = 1'($urandom_range(0, 1));
                any += rem[i];
            end
            if (any == 0) rem[$urandom_range(0, N-1)] = 1;
            run_batch("random");
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never reports busy: watchdog must close the transfer.
        clr(); rem[3] = 1; tie0 = 1'b1; expect_tmo = 1'b1;
        run_batch("timeout");
        tie0 = 1'b0; expect_tmo = 1'b0;
`endif

        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter PRESC_W, default 16, width of the baud prescale value.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in clk cycles.
REQ-004 The block SHALL have one clock and asynchronous active-high reset: clk  in  1  system clock; rst  in  1  reset.
REQ-005 The block SHALL have port req  in  NUM_REQ  per-requester transmit request, level.
REQ-006 The block SHALL have port req_data  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port req_prescale  in  PRESC_W*NUM_REQ  baud divider per requester; same slicing rule.
REQ-008 The block SHALL have port ack  out  NUM_REQ  one-cycle pulse to the granted requester when its byte is finished.
REQ-009 The block SHALL have ports uart_tx_start  out  1  start pulse; uart_tx_data  out  8  byte; uart_prescale  out  PRESC_W  divider; uart_tx_busy  in  1  transmitter busy.
REQ-010 The block SHALL have ports grant_id  out  $clog2(NUM_REQ)  current owner; arb_busy  out  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, START, WAIT_BUSY, WAIT_DONE, DONE.
REQ-012 In IDLE with any req bit high, the block SHALL select a winner round-robin, starting the search at rr_ptr, and go to SETUP.
REQ-013 On that transition, grant_id, uart_tx_data and uart_prescale SHALL be registered from the winner's slices.
REQ-014 SETUP SHALL last exactly one cycle, so the prescale is stable before start; the FSM then goes to START.
REQ-015 START SHALL drive uart_tx_start high for exactly one cycle, then go to WAIT_BUSY.
REQ-016 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle uart_tx_busy=1.
REQ-017 WAIT_DONE SHALL go to DONE on the first cycle uart_tx_busy=0.
REQ-018 DONE SHALL pulse ack[grant_id] for one cycle, set rr_ptr to (grant_id+1) mod NUM_REQ, and return to IDLE.
REQ-019 Latency from req rising in IDLE to uart_tx_start high SHALL be 2 cycles.
REQ-020 uart_tx_data and uart_prescale SHALL hold constant from SETUP through DONE, and hold the last values while in IDLE.
REQ-021 Requests SHALL be sampled only in IDLE; once a grant is made, the transfer SHALL complete even if that req drops.
REQ-022 A req still high in the cycle after its ack SHALL be treated as a new request, subject to round-robin order.
REQ-023 When several requests arrive simultaneously, the lowest index at or after rr_ptr SHALL win, with wrap-around from NUM_REQ-1 to 0.
REQ-024 Only one ack bit SHALL ever be high at a time.

Reset
REQ-025 Asserting rst SHALL immediately force: state IDLE, rr_ptr 0, grant_id 0, ack 0, uart_tx_start 0, uart_tx_data 0x00, uart_prescale 868, arb_busy 0.
REQ-026 Reset mid-transfer SHALL drop the transfer with no ack pulse.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, the block SHALL add output port timeout_err (1 bit) and a cycle counter.
REQ-028 The cycle counter SHALL clear on entering WAIT_BUSY and on entering WAIT_DONE, and SHALL count while in either state.
REQ-029 With UART_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL pulse timeout_err for one cycle and go to DONE, which still pulses ack and advances rr_ptr.
REQ-030 With UART_ARB_TIMEOUT_EN undefined, timeout_err and the counter SHALL be absent, and WAIT_BUSY/WAIT_DONE SHALL wait indefinitely.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the default prescale constant DEF_PRESCALE=868, and the UART byte width 8.
REQ-032 The round-robin priority picker SHALL be a sub-module uart_rr_pick (inputs req, rr_ptr; outputs valid, idx).

Verification
REQ-033 The bench SHALL cover: req=0001, data0=0xA5, presc0=868, with a UART model -> tx_start 2 cycles after req; one ack[0] after busy falls; 0xA5 received.
REQ-034 The bench SHALL cover: req=1111 held, rr_ptr=0 -> grant order 0,1,2,3,0, with ack pulses in that order.
REQ-035 The bench SHALL cover: req0 presc=10416 and req2 presc=100 simultaneous -> uart_prescale=10416 throughout byte 0, then 100 for byte 2; both bytes correct.
REQ-036 The bench SHALL cover: req1 dropped during WAIT_DONE -> transfer completes and ack[1] still pulses.
REQ-037 The bench SHALL cover: rst asserted during WAIT_DONE -> uart_tx_start=0, arb_busy=0 and no ack in the same cycle.
REQ-038 The bench SHALL cover, with UART_ARB_TIMEOUT_EN defined: uart_tx_busy tied 0, TIMEOUT_CYC=16 -> timeout_err pulse 16 cycles after WAIT_BUSY entry, then an ack pulse.
